dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port. Accepts one load/store request at a time over a valid/ready handshake and applies byte-strobe writes to an internal word-addressed array.
- Returns a response (read data or write ack) after a programmable number of wait states. It is the slave end of the bus the datapath drives once dmem moves off the async-RAM model.
- Only one request is outstanding at a time; no reordering.

Parameters:
DWIDTH, 32, data word width; must be a multiple of 8
AWIDTH, 14, word-address width
DEPTH, 16384, number of implemented words; addresses >= DEPTH are out of range
WAIT_STATES, 2, extra cycles between request acceptance and response valid (0..15)
MIF_HEX, "", optional hex init file for the array; empty means no init

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  responder can accept a request this cycle
req_addr  in  AWIDTH  word address
req_wbe  in  DWIDTH/8  byte write enables; all-zero means read
req_wdata  in  DWIDTH  write data, byte lanes pre-aligned by the requester
resp_valid  out  1  response present
resp_ready  in  1  requester accepts the response
resp_rdata  out  DWIDTH  read data; 0 for writes and errors
resp_err  out  1  request addressed out of range

Behaviour:
- Reset (rst=0 at a rising edge):
  - state goes to IDLE, wait counter goes to 0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=0 while rst=0.
  - Array contents are preserved.
  - Reset mid-transaction discards the pending response; any write already committed stays committed.
- States:
  - IDLE: req_ready=1.
  - WAIT: counting wait states, req_ready=0.
  - RESP: resp_valid=1, req_ready=0.
- Accept: req_valid & req_ready at edge T.
  - Latch addr and wbe.
  - Write path: if addr < DEPTH, write each lane i with wbe[i]=1 at edge T. Lanes with wbe[i]=0 are unchanged.
  - Read path (wbe=0): sample the array word at edge T into the response register.
  - Out of range: no write, response data 0, resp_err=1.
- Timing after accept:
  - WAIT_STATES=0: go directly to RESP; resp_valid=1 in cycle T+1.
  - Otherwise: go to WAIT, load counter with WAIT_STATES-1, decrement each cycle, and go to RESP when the counter is 0. resp_valid first high in cycle T+1+WAIT_STATES.
- RESP:
  - resp_valid, resp_rdata and resp_err hold stable until resp_ready=1 at an edge.
  - On that edge go to IDLE and clear resp_valid, resp_rdata and resp_err to 0.
  - Minimum spacing between accepts is WAIT_STATES+2 cycles (one idle bubble after handshake).
- req_valid while req_ready=0 is ignored. The requester must hold the request, and the responder does not buffer it.
- resp_ready while resp_valid=0 is ignored.
- A write response has resp_rdata=0 and resp_err=0 for an in-range address.
- Counter width is 4 bits; WAIT_STATES > 15 is illegal. Flag it with an elaboration-time error.
- A partial-strobe write followed by a read returns the merged word. There is no read-side masking; sign/zero extension stays in the datapath.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0 throughout; req_ready=1 the first cycle after rst=1.
- Word write/read, WAIT_STATES=2:
  - write addr 0x0010, wbe=4'b1111, wdata 0xDEADBEEF accepted at T -> resp_valid rises at T+3 with rdata 0, err 0.
  - read addr 0x0010 -> rdata 0xDEADBEEF.
- Byte merge, WAIT_STATES=0:
  - preload 0x11223344 at addr 5, then write wbe=4'b0100, wdata 0x00AA0000 -> resp_valid at T+1.
  - read addr 5 -> 0x11AA3344.
- Backpressure:
  - read response valid with resp_ready=0 for 4 cycles -> resp_valid and rdata stable, req_ready=0 with req_valid=1 held.
  - resp_ready=1 -> next cycle req_ready=1 and the held request is accepted.
- Out of range, DEPTH=16:
  - write addr 20 with 0xFFFFFFFF -> resp_err=1, rdata 0.
  - read of addr 4 (20 mod 16) is unchanged.
- Reset mid-WAIT: accept read with WAIT_STATES=5, assert rst=0 at T+2 -> resp_valid never rises; IDLE after release; an earlier committed write remains readable.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side slave for the core's data-memory port.
// Accepts one load/store at a time over valid/ready, applies byte-strobe
// writes to a word-addressed array, and returns read data or a write ack
// after WAIT_STATES extra cycles.
//
// Ports:
//   clk         clock, all logic on rising edge
//   rst         synchronous reset, active-low
//   req_valid   request present
//   req_ready   responder can accept a request this cycle
//   req_addr    word address
//   req_wbe     byte write enables; all-zero means read
//   req_wdata   write data, byte lanes pre-aligned
//   resp_valid  response present
//   resp_ready  requester accepts the response
//   resp_rdata  read data; 0 for writes and errors
//   resp_err    request addressed out of range
module dmem_responder #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned AWIDTH      = 14,
  parameter int unsigned DEPTH       = 16384,
  parameter int unsigned WAIT_STATES = 2,
  parameter string       MIF_HEX     = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH/8-1:0] req_wbe,
  input  logic [DWIDTH-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DWIDTH-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int unsigned NLANES = DWIDTH / 8;
  localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW     = 4;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES == 0) ? '0 : CW'(WAIT_STATES - 1);

  // Elaboration-time parameter checks
  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_STATES must be in 0..15");
  end
  if ((DWIDTH == 0) || (DWIDTH % 8 != 0)) begin : g_bad_dwidth
    $error("dmem_responder: DWIDTH must be a non-zero multiple of 8");
  end
  if ((AWIDTH > 32) || (IW > AWIDTH)) begin : g_bad_awidth
    $error("dmem_responder: DEPTH does not fit in AWIDTH address bits");
  end
  // File preload needs a simulation-only initial block, which this RTL does
  // not carry; reject a path rather than silently leaving the array empty.
  if (MIF_HEX != "") begin : g_no_mif
    $error("dmem_responder: MIF_HEX preload is not supported in this RTL");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              ready_q;
  logic [DWIDTH-1:0] pend_rdata;
  logic              pend_err;
  logic [DWIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]     idx_c;
  logic              in_range_c;
  logic              is_write_c;
  logic              accept_c;
  logic [DWIDTH-1:0] rd_value_c;

  // Request decode
  assign idx_c      = req_addr[IW-1:0];
  assign in_range_c = (33'(req_addr) < 33'(DEPTH));
  assign is_write_c = |req_wbe;
  assign rd_value_c = (in_range_c && !is_write_c) ? mem[idx_c] : '0;

  // Ready is forced low for the whole time rst is asserted
  assign req_ready = ready_q & rst;
  assign accept_c  = req_valid & req_ready;

  // Byte-strobe write; array is never reset
  always_ff @(posedge clk) begin
    if (accept_c && in_range_c) begin
      for (int i = 0; i < int'(NLANES); i++) begin
        if (req_wbe[i]) begin
          mem[idx_c][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Request/response sequencing
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ready_q    <= 1'b0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept_c) begin
            ready_q    <= 1'b0;
            pend_rdata <= rd_value_c;
            pend_err   <= ~in_range_c;
            if (WAIT_STATES == 0) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rd_value_c;
              resp_err   <= ~in_range_c;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= pend_rdata;
            resp_err   <= pend_err;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            ready_q    <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances with different wait-state
// and depth settings, table-driven vectors, hand-written multi-cycle
// sequences, and randomized traffic checked against a word-array model.
module tb_dmem_responder;

  localparam int unsigned NDUT  = 3;
  localparam int unsigned MAXDP = 64;
  localparam int unsigned WS_TAB [NDUT] = '{2, 0, 5};
  localparam int unsigned DP_TAB [NDUT] = '{64, 16, 16};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic [13:0] req_addr   [NDUT];
  logic [3:0]  req_wbe    [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic        resp_valid [NDUT];
  logic        resp_ready [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_err   [NDUT];

  for (genvar g = 0; g < int'(NDUT); g++) begin : g_dut
    dmem_responder #(
      .DWIDTH(32),
      .AWIDTH(14),
      .DEPTH(DP_TAB[g]),
      .WAIT_STATES(WS_TAB[g]),
      .MIF_HEX("")
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr(req_addr[g]),
      .req_wbe(req_wbe[g]),
      .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err(resp_err[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain word array per instance
  logic [31:0] mdl [NDUT][MAXDP];

  typedef struct {
    int          k;
    logic [13:0] addr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies a transaction to the model and returns the expected response
  function automatic void model_apply(input int k, input logic [13:0] a, input logic [3:0] wbe,
                                      input logic [31:0] wd, output logic [31:0] er, output logic ee);
    er = 32'h0;
    ee = 1'b0;
    if (int'(a) >= int'(DP_TAB[k])) begin
      ee = 1'b1;
    end else if (wbe == 4'h0) begin
      er = mdl[k][a];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mdl[k][a][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endfunction

  task automatic issue(input int k, input logic [13:0] a, input logic [3:0] wbe, input logic [31:0] wd);
    int n = 0;
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    req_wbe[k]   = wbe;
    req_wdata[k] = wd;
    while (!req_ready[k] && n < 50) begin
      tick();
      n++;
    end
    chk("ready_before_accept", k, 32'(req_ready[k]), 32'd1);
    tick();
    req_valid[k] = 1'b0;
    chk("ready_after_accept", k, 32'(req_ready[k]), 32'd0);
  endtask

  task automatic wait_resp(input int k, input logic [31:0] er, input logic ee);
    int c = 0;
    while (!resp_valid[k] && c < 40) begin
      tick();
      c++;
    end
    chk("latency", k, 32'(c), 32'(WS_TAB[k]));
    chk("resp_valid", k, 32'(resp_valid[k]), 32'd1);
    chk("resp_rdata", k, resp_rdata[k], er);
    chk("resp_err", k, 32'(resp_err[k]), 32'(ee));
  endtask

  task automatic hold_resp(input int k, input int n, input logic [31:0] er);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("hold_valid", k, 32'(resp_valid[k]), 32'd1);
      chk("hold_rdata", k, resp_rdata[k], er);
      chk("hold_ready", k, 32'(req_ready[k]), 32'd0);
    end
  endtask

  task automatic release_resp(input int k);
    resp_ready[k] = 1'b1;
    tick();
    resp_ready[k] = 1'b0;
    chk("post_valid", k, 32'(resp_valid[k]), 32'd0);
    chk("post_rdata", k, resp_rdata[k], 32'd0);
    chk("post_err", k, 32'(resp_err[k]), 32'd0);
    chk("post_ready", k, 32'(req_ready[k]), 32'd1);
  endtask

  task automatic do_txn(input int k, input logic [13:0] a, input logic [3:0] wbe, input logic [31:0] wd,
                        input int hold, input logic [31:0] er, input logic ee);
    issue(k, a, wbe, wd);
    wait_resp(k, er, ee);
    hold_resp(k, hold, er);
    release_resp(k);
  endtask

  initial begin
    logic [31:0] er;
    logic        ee;
    logic [13:0] a;
    logic [3:0]  wbe;
    logic [31:0] wd;
    int          k;

    for (int d = 0; d < int'(NDUT); d++) begin
      req_valid[d]  = 1'b1;
      req_addr[d]   = '0;
      req_wbe[d]    = '0;
      req_wdata[d]  = '0;
      resp_ready[d] = 1'b0;
      for (int w = 0; w < int'(MAXDP); w++) mdl[d][w] = 32'h0;
    end

    // Reset held with requests pending
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < int'(NDUT); d++) begin
        chk("rst_ready", d, 32'(req_ready[d]), 32'd0);
        chk("rst_valid", d, 32'(resp_valid[d]), 32'd0);
        chk("rst_rdata", d, resp_rdata[d], 32'd0);
        chk("rst_err", d, 32'(resp_err[d]), 32'd0);
      end
    end
    rst = 1'b1;
    for (int d = 0; d < int'(NDUT); d++) req_valid[d] = 1'b0;
    tick();
    for (int d = 0; d < int'(NDUT); d++) chk("ready_after_rst", d, 32'(req_ready[d]), 32'd1);

    // Preload every word so the model is fully defined
    for (int d = 0; d < int'(NDUT); d++) begin
      for (int w = 0; w < int'(DP_TAB[d]); w++) begin
        wd = $urandom;
        model_apply(d, 14'(w), 4'hF, wd, er, ee);
        do_txn(d, 14'(w), 4'hF, wd, 0, er, ee);
      end
    end

    // Directed vectors with hand-computed expectations
    vecs[0]  = '{0, 14'h0010, 4'hF, 32'hDEADBEEF, 0, 32'h0, 1'b0};
    vecs[1]  = '{0, 14'h0010, 4'h0, 32'h0,        1, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1, 14'd5,    4'hF, 32'h11223344, 0, 32'h0, 1'b0};
    vecs[3]  = '{1, 14'd5,    4'h4, 32'h00AA0000, 0, 32'h0, 1'b0};
    vecs[4]  = '{1, 14'd5,    4'h0, 32'h0,        2, 32'h11AA3344, 1'b0};
    vecs[5]  = '{1, 14'd4,    4'hF, 32'h0BADF00D, 0, 32'h0, 1'b0};
    vecs[6]  = '{1, 14'd20,   4'hF, 32'hFFFFFFFF, 0, 32'h0, 1'b1};
    vecs[7]  = '{1, 14'd4,    4'h0, 32'h0,        0, 32'h0BADF00D, 1'b0};
    vecs[8]  = '{1, 14'd20,   4'h0, 32'h0,        0, 32'h0, 1'b1};
    vecs[9]  = '{2, 14'd3,    4'hF, 32'hA5A55A5A, 3, 32'h0, 1'b0};
    vecs[10] = '{2, 14'd3,    4'h0, 32'h0,        0, 32'hA5A55A5A, 1'b0};
    vecs[11] = '{0, 14'd63,   4'hF, 32'h12345678, 0, 32'h0, 1'b0};
    vecs[12] = '{0, 14'd63,   4'h0, 32'h0,        0, 32'h12345678, 1'b0};
    vecs[13] = '{0, 14'd64,   4'h0, 32'h0,        1, 32'h0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      model_apply(vecs[i].k, vecs[i].addr, vecs[i].wbe, vecs[i].wdata, er, ee);
      do_txn(vecs[i].k, vecs[i].addr, vecs[i].wbe, vecs[i].wdata, vecs[i].hold,
             vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Backpressure with the next request held on the bus
    issue(0, 14'h0010, 4'h0, 32'h0);
    wait_resp(0, 32'hDEADBEEF, 1'b0);
    req_valid[0] = 1'b1;
    req_addr[0]  = 14'd63;
    req_wbe[0]   = 4'h0;
    hold_resp(0, 4, 32'hDEADBEEF);
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    chk("bp_valid_drop", 0, 32'(resp_valid[0]), 32'd0);
    chk("bp_ready_rise", 0, 32'(req_ready[0]), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    chk("bp_held_accepted", 0, 32'(req_ready[0]), 32'd0);
    wait_resp(0, 32'h12345678, 1'b0);
    release_resp(0);

    // Reset in the middle of the wait-state count
    issue(2, 14'd3, 4'h0, 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("midrst_valid", 2, 32'(resp_valid[2]), 32'd0);
      chk("midrst_ready", 2, 32'(req_ready[2]), 32'd0);
    end
    rst = 1'b1;
    tick();
    chk("midrst_idle_ready", 2, 32'(req_ready[2]), 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("midrst_no_resp", 2, 32'(resp_valid[2]), 32'd0);
    end
    do_txn(2, 14'd3, 4'h0, 32'h0, 0, 32'hA5A55A5A, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      k   = int'($urandom_range(0, NDUT - 1));
      a   = 14'($urandom_range(0, DP_TAB[k] + 7));
      wbe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wd  = $urandom;
      model_apply(k, a, wbe, wd, er, ee);
      do_txn(k, a, wbe, wd, int'($urandom_range(0, 3)), er, ee);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
